// File: rtl/hdmi_pkg.sv
// Shared constants and types for the HDMI convolution datapath.
package hdmi_pkg;
  localparam int PIX_W = 24;
  localparam int ST_W  = 3;

  // Status bits arrive as {de, hsync, vsync}.
  localparam int ST_DE = 2;
  localparam int ST_HS = 1;
  localparam int ST_VS = 0;

  localparam int DEFAULT_LINE_LEN = 1650;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [ST_W-1:0]  status_t;

  typedef struct packed {
    status_t stat;
    pixel_t  pix;
  } tagged_pix_t;
endpackage

// File: rtl/line_ram.sv
// Single-port, read-first block RAM with a registered read port.
module line_ram #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 1650,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: no reset on mem or rdata so the array maps onto block RAM; both
  // assignments are non-blocking, so rdata gets the old word (read-first).
  always_ff @(posedge clk) begin
    rdata     <= mem[addr];
    mem[addr] <= wdata;
  end
endmodule

// File: rtl/bram_line_delay.sv
// Five-row vertical tap generator for the 5x5 convolution window, built from
// four chained line buffers with fill gating to hide stale RAM after reset.
module bram_line_delay
  import hdmi_pkg::*;
#(
  parameter int LINE_LEN = DEFAULT_LINE_LEN,
  parameter int AW       = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PIX_W-1:0]    data_in,
  input  logic [ST_W-1:0]     stat_in,
  output logic [PIX_W-1:0]    pa,
  output logic [PIX_W-1:0]    pb,
  output logic [PIX_W-1:0]    pc,
  output logic [PIX_W-1:0]    pd,
  output logic [PIX_W-1:0]    pe,
  output logic [ST_W-1:0]     stat_o
);
  localparam int TAG_W = $bits(tagged_pix_t);

  // The registered read port supplies one cycle of each line's delay, so the
  // RAM ring holds LINE_LEN-1 words to keep adjacent taps LINE_LEN apart.
  localparam int RAM_DEPTH = LINE_LEN - 1;

  localparam logic [AW-1:0] LAST_COL = AW'(LINE_LEN - 1);
  localparam logic [AW-1:0] LAST_RAM = AW'(LINE_LEN - 2);
  localparam logic [2:0]    FILL_MAX = 3'd4;

  logic [AW-1:0] addr;
  logic [AW-1:0] ram_addr;
  logic [2:0]    fill;
  tagged_pix_t   stage0;
  tagged_pix_t   rd0;
  tagged_pix_t   rd1;
  pixel_t        rd2;
  pixel_t        rd3;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      ram_addr <= '0;
      fill     <= '0;
      stage0   <= '0;
    end else begin
      addr     <= (addr == LAST_COL) ? '0 : addr + 1'b1;
      ram_addr <= (ram_addr == LAST_RAM) ? '0 : ram_addr + 1'b1;
      if (addr == LAST_COL && fill != FILL_MAX)
        fill <= fill + 1'b1;
      stage0   <= '{stat: stat_in, pix: data_in};
    end
  end

  line_ram #(.WIDTH(TAG_W), .DEPTH(RAM_DEPTH), .AW(AW)) u_buf0 (
    .clk   (clk),
    .addr  (ram_addr),
    .wdata (stage0),
    .rdata (rd0)
  );

  line_ram #(.WIDTH(TAG_W), .DEPTH(RAM_DEPTH), .AW(AW)) u_buf1 (
    .clk   (clk),
    .addr  (ram_addr),
    .wdata (rd0),
    .rdata (rd1)
  );

  // Status stops at the centre row; the older rows carry pixels only.
  line_ram #(.WIDTH(PIX_W), .DEPTH(RAM_DEPTH), .AW(AW)) u_buf2 (
    .clk   (clk),
    .addr  (ram_addr),
    .wdata (rd1.pix),
    .rdata (rd2)
  );

  line_ram #(.WIDTH(PIX_W), .DEPTH(RAM_DEPTH), .AW(AW)) u_buf3 (
    .clk   (clk),
    .addr  (ram_addr),
    .wdata (rd2),
    .rdata (rd3)
  );

  assign pa     = stage0.pix;
  assign pb     = (fill >= 3'd1) ? rd0.pix  : '0;
  assign pc     = (fill >= 3'd2) ? rd1.pix  : '0;
  assign stat_o = (fill >= 3'd2) ? rd1.stat : '0;
  assign pd     = (fill >= 3'd3) ? rd2      : '0;
  assign pe     = (fill >= 3'd4) ? rd3      : '0;
endmodule

// File: tb/tb_bram_line_delay.sv
// Directed bench for bram_line_delay at LINE_LEN of 16, 5 and 1650.
module tb_bram_line_delay;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, rst_c;
  logic [23:0] din_a, din_b, din_c;
  logic [2:0]  st_a, st_b, st_c;
  logic [23:0] pa_a, pb_a, pc_a, pd_a, pe_a;
  logic [23:0] pa_b, pb_b, pc_b, pd_b, pe_b;
  logic [23:0] pa_c, pb_c, pc_c, pd_c, pe_c;
  logic [2:0]  so_a, so_b, so_c;

  bram_line_delay #(.LINE_LEN(16), .AW(4)) dut_a (
    .clk(clk), .rst(rst_a), .data_in(din_a), .stat_in(st_a),
    .pa(pa_a), .pb(pb_a), .pc(pc_a), .pd(pd_a), .pe(pe_a), .stat_o(so_a));

  bram_line_delay #(.LINE_LEN(5), .AW(3)) dut_b (
    .clk(clk), .rst(rst_b), .data_in(din_b), .stat_in(st_b),
    .pa(pa_b), .pb(pb_b), .pc(pc_b), .pd(pd_b), .pe(pe_b), .stat_o(so_b));

  bram_line_delay dut_c (
    .clk(clk), .rst(rst_c), .data_in(din_c), .stat_in(st_c),
    .pa(pa_c), .pb(pb_c), .pc(pc_c), .pd(pd_c), .pe(pe_c), .stat_o(so_c));

  int errors = 0;
  int checks = 0;

  // hist[n] is {stat, pixel} sampled at the n-th edge after reset release;
  // hist[0] is the cleared input register.
  logic [26:0] hist [0:8191];
  int n;

  function automatic logic [23:0] tap_exp(input int k, input int len);
    if (k == 0)       return hist[n][23:0];
    if (n >= k * len) return hist[n - k * len][23:0];
    return 24'd0;
  endfunction

  function automatic logic [2:0] st_exp(input int len);
    if (n >= 2 * len) return hist[n - 2 * len][26:24];
    return 3'd0;
  endfunction

  task automatic restart_model;
    n = 0;
    hist[0] = '0;
  endtask

  task automatic step_a(input logic [23:0] d, input logic [2:0] s);
    din_a = d; st_a = s;
    @(posedge clk); #1;
    n++; hist[n] = {s, d};
  endtask

  task automatic step_b(input logic [23:0] d, input logic [2:0] s);
    din_b = d; st_b = s;
    @(posedge clk); #1;
    n++; hist[n] = {s, d};
  endtask

  task automatic step_c(input logic [23:0] d, input logic [2:0] s);
    din_c = d; st_c = s;
    @(posedge clk); #1;
    n++; hist[n] = {s, d};
  endtask

  task automatic test_reset;
    logic [23:0] got [5];
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    din_a = 24'hffffff; din_b = 24'hffffff; din_c = 24'hffffff;
    st_a = 3'b111; st_b = 3'b111; st_c = 3'b111;
    repeat (5) @(posedge clk);
    #1;
    got = '{pa_a, pb_a, pc_a, pd_a, pe_a};
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (got[k] !== 24'd0) begin
        errors++;
        $display("FAIL reset tap%0d got=%h exp=000000", k, got[k]);
      end
    end
    checks++;
    if (so_a !== 3'd0) begin
      errors++;
      $display("FAIL reset stat_o got=%b exp=000", so_a);
    end
    checks++;
    if (pa_b !== 24'd0 || pa_c !== 24'd0) begin
      errors++;
      $display("FAIL reset pa_bc got=%h/%h exp=000000", pa_b, pa_c);
    end
    rst_a = 1'b0;
    restart_model();
  endtask

  task automatic test_ramp;
    logic [23:0] got [5];
    for (int i = 0; i < 100; i++) begin
      step_a(24'(i), 3'd0);
      got = '{pa_a, pb_a, pc_a, pd_a, pe_a};
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (got[k] !== tap_exp(k, 16)) begin
          errors++;
          $display("FAIL ramp tap%0d n=%0d got=%h exp=%h", k, n, got[k], tap_exp(k, 16));
        end
      end
      if (n >= 65) begin
        checks++;
        if (24'(pa_a - pb_a) !== 24'd16 || 24'(pb_a - pc_a) !== 24'd16 ||
            24'(pc_a - pd_a) !== 24'd16 || 24'(pd_a - pe_a) !== 24'd16) begin
          errors++;
          $display("FAIL ramp_spacing n=%0d got=%h %h %h %h %h exp=steps of 16",
                   n, pa_a, pb_a, pc_a, pd_a, pe_a);
        end
      end
      if (n == 66) begin
        checks++;
        if (pe_a !== 24'd1) begin
          errors++;
          $display("FAIL ramp_pe_first n=%0d got=%h exp=000001", n, pe_a);
        end
      end
    end
  endtask

  task automatic test_mid_reset;
    logic [23:0] got [5];
    rst_a = 1'b1;
    @(posedge clk); #1;
    got = '{pa_a, pb_a, pc_a, pd_a, pe_a};
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (got[k] !== 24'd0) begin
        errors++;
        $display("FAIL midrst_clear tap%0d got=%h exp=000000", k, got[k]);
      end
    end
    rst_a = 1'b0;
    restart_model();
    for (int i = 0; i < 80; i++) begin
      step_a(24'(1000 + i), 3'b101);
      if (n <= 16) begin
        checks++;
        if (pb_a !== 24'd0) begin
          errors++;
          $display("FAIL midrst_gate_pb n=%0d got=%h exp=000000", n, pb_a);
        end
      end
      got = '{pa_a, pb_a, pc_a, pd_a, pe_a};
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (got[k] !== tap_exp(k, 16)) begin
          errors++;
          $display("FAIL midrst tap%0d n=%0d got=%h exp=%h", k, n, got[k], tap_exp(k, 16));
        end
      end
      checks++;
      if (so_a !== st_exp(16)) begin
        errors++;
        $display("FAIL midrst_stat n=%0d got=%b exp=%b", n, so_a, st_exp(16));
      end
    end
  endtask

  task automatic test_status;
    int w [3];
    int left [3];
    logic [2:0] s;
    rst_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    restart_model();
    // Pulse widths 2,4,6,... on every bit; bit1 starts high, bit2 starts 3 cycles late.
    s = 3'b010;
    w = '{2, 2, 2};
    left = '{2, 2, 5};
    for (int i = 0; i < 200; i++) begin
      step_a(24'($urandom), s);
      for (int j = 0; j < 3; j++) begin
        left[j]--;
        if (left[j] == 0) begin
          s[j] = ~s[j];
          w[j] += 2;
          left[j] = w[j];
        end
      end
      checks++;
      if (so_a !== st_exp(16)) begin
        errors++;
        $display("FAIL status n=%0d got=%b exp=%b", n, so_a, st_exp(16));
      end
      checks++;
      if (pc_a !== tap_exp(2, 16)) begin
        errors++;
        $display("FAIL status_pc n=%0d got=%h exp=%h", n, pc_a, tap_exp(2, 16));
      end
    end
  endtask

  task automatic test_wrap;
    logic [23:0] got [5];
    rst_b = 1'b0;
    restart_model();
    for (int i = 0; i < 220; i++) begin
      step_b(24'($urandom), 3'($urandom));
      got = '{pa_b, pb_b, pc_b, pd_b, pe_b};
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (got[k] !== tap_exp(k, 5)) begin
          errors++;
          $display("FAIL wrap tap%0d n=%0d got=%h exp=%h", k, n, got[k], tap_exp(k, 5));
        end
      end
      checks++;
      if (so_b !== st_exp(5)) begin
        errors++;
        $display("FAIL wrap_stat n=%0d got=%b exp=%b", n, so_b, st_exp(5));
      end
    end
  endtask

  task automatic test_default;
    rst_c = 1'b0;
    restart_model();
    for (int i = 0; i < 6650; i++) begin
      step_c(24'(i), 3'd0);
      if (n == 6599) begin
        checks++;
        if (pe_c !== 24'd0) begin
          errors++;
          $display("FAIL default_gate_pe n=%0d got=%h exp=000000", n, pe_c);
        end
      end
      if (n >= 6601) begin
        checks++;
        if (pe_c !== 24'(pa_c - 24'd6600) || pb_c !== 24'(pa_c - 24'd1650)) begin
          errors++;
          $display("FAIL default_ramp n=%0d got pa=%h pb=%h pe=%h exp pa-1650/pa-6600",
                   n, pa_c, pb_c, pe_c);
        end
        checks++;
        if (pa_c !== 24'(n - 1)) begin
          errors++;
          $display("FAIL default_pa n=%0d got=%h exp=%h", n, pa_c, 24'(n - 1));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_mid_reset();
    test_status();
    test_wrap();
    test_default();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
